lfsr_axis_writer: RTL and testbench
===================================

# lfsr_axis_writer

Pattern-generating AXI-Stream master that drives the byte-write slave port of the on-chip AXI-Stream RAM. On a start command it writes a run of LFSR bytes to consecutive RAM addresses. It can then read every byte back through the RAM's debug read port, regenerate the same LFSR sequence, and count mismatches. It is the stimulus/self-check end of the LFSR RAM path and also serves as a built-in memory test.

## Interface
- LFSR_TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1)
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  8  first RAM address
- length  in  9  byte count; 0 = no-op; values >256 clamp to 256
- seed  in  8  LFSR seed; 8'h00 is replaced by 8'h01
- verify_en  in  1  run read-back check after the write phase
- m_axis_tdata  out  32  beat: [31:24]=0, [23:16]=addr, [15:8]=0, [7:0]=data
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  slave ready
- debug_addr  out  8  read-back address
- debug_rd_en  out  1  read-back strobe
- debug_rdata  in  32  read-back data; [7:0] used, valid the cycle after debug_rd_en
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at completion
- error_count  out  9  mismatches in the last verify; cleared on start
- first_err_addr  out  8  address of the first mismatch; 0 if none

## Operation
- Reset values: all outputs 0; FSM in IDLE; LFSR = 8'h01.
- LFSR step: next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 0).
- Beat k carries data = LFSR state k, where state 0 is the seed.
- Addresses: base_addr + k, 8-bit, wrapping 0xFF -> 0x00.
- IDLE
  - When start is high, latch base_addr, the clamped length, seed (zero-fixed) and verify_en.
  - Clear error_count and first_err_addr.
  - length 0 -> DONE. Otherwise -> WRITE.
- WRITE
  - Hold m_axis_tvalid high.
  - tdata must stay stable while tvalid=1 and tready=0.
  - On each handshake, advance the LFSR and address and decrement the remaining count.
  - After the last handshake, deassert tvalid in the same edge and reload LFSR = seed.
  - Then go to VREQ if verify_en, otherwise DONE.
- VREQ
  - Drive debug_rd_en=1 for one cycle with debug_addr = current address.
  - -> VCHK.
- VCHK
  - Compare debug_rdata[7:0] with the LFSR state.
  - On mismatch, increment error_count (saturates at 256). If this is the first mismatch, capture first_err_addr.
  - Advance the LFSR and address.
  - -> VREQ if bytes remain, otherwise DONE.
- DONE
  - Pulse done for one cycle, drop busy.
  - -> IDLE. error_count and first_err_addr hold until the next start.
- start outside IDLE is ignored.
- Reset asserted mid-operation aborts immediately. tvalid drops asynchronously, and no partial state survives.

## Timing
- start at edge N -> busy=1 and m_axis_tvalid=1 after edge N+1.
- One beat per cycle with tready held high. Against the RAM, which pauses tready one cycle after each beat, one beat per 2 cycles.
- Verify costs 2 cycles per byte (VREQ, VCHK).
- Minimum completion cycles after start:
  - Write only: length + 2.
  - With verify: add 2 x length.
  - length 0: done 2 cycles after start; no beats, no reads.
- The last RAM write lands at its handshake edge, which is before the first VREQ. No extra gap is needed.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, WRITE, VREQ, VCHK, DONE).
  - The tdata field positions (address [23:16], data [7:0]), common with the RAM.
  - The default tap mask.
- Natural sub-module: lfsr8_step, a combinational next-state function parameterised by LFSR_TAPS. Both the write and verify phases instantiate it.

## Test plan
- Write only, seed 8'h01, base 8'h10, length 4, tready=1:
  - Beats 0x00100001, 0x001100B8, 0x0012005C, 0x0013002E on consecutive cycles.
  - done pulses 1 cycle after the last beat.
- Backpressure: tready toggling 1/0 (RAM model) and random stalls.
  - tdata is stable across every stall.
  - No beat is dropped or duplicated.
  - RAM contents at 0x10..0x13 = 01, B8, 5C, 2E.
- Wrap and clamp, base 8'hFE, length 9'd300, seed 0:
  - 256 beats in total, addresses FE, FF, 00 … FD.
  - First data byte is 01.
- Verify against the RAM model with an injected fault (force mem[0x12]=00 after the write), length 4:
  - error_count=1, first_err_addr=8'h12.
  - Clean run gives error_count=0.
- length 0, and start pulses while busy:
  - No beats, done 2 cycles after start.
  - The mid-run start does not restart the sequence.
- aresetn low during WRITE beat 2:
  - tvalid, busy and done are 0 immediately.
  - After release the block idles until the next start.

Source files
------------

// File: rtl/lfsr_axis_writer_pkg.sv
// Shared definitions for the LFSR pattern writer: FSM encoding, AXI-Stream beat
// layout (common with the AXI-Stream RAM) and the default feedback mask.
package lfsr_axis_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_VREQ  = 3'd2,
    ST_VCHK  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
  localparam int unsigned TDATA_ADDR_LSB = 16;
  localparam int unsigned TDATA_DATA_LSB = 0;
  localparam logic [8:0] MAX_LEN = 9'd256;

  function automatic logic [31:0] pack_beat(input logic [7:0] addr, input logic [7:0] data);
    logic [31:0] beat;
    beat = '0;
    beat[TDATA_ADDR_LSB +: 8] = addr;
    beat[TDATA_DATA_LSB +: 8] = data;
    return beat;
  endfunction

  function automatic logic [8:0] clamp_len(input logic [8:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [7:0] fix_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

// File: rtl/lfsr_axis_writer_lfsr8_step.sv
// Combinational next-state of an 8-bit Galois LFSR with a configurable tap mask.
module lfsr8_step #(
  parameter logic [7:0] LFSR_TAPS = 8'hB8
) (
  input  logic [7:0] state_i,
  output logic [7:0] next_o
);

  assign next_o = (state_i >> 1) ^ (state_i[0] ? LFSR_TAPS : 8'h00);

endmodule

// File: rtl/lfsr_axis_writer.sv
// AXI-Stream master writing an LFSR byte run into the stream RAM, with optional
// read-back through the RAM debug port and mismatch counting.
module lfsr_axis_writer
  import lfsr_axis_writer_pkg::*;
#(
  parameter logic [7:0] LFSR_TAPS = DEFAULT_TAPS
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [8:0]  length,
  input  logic [7:0]  seed,
  input  logic        verify_en,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  debug_addr,
  output logic        debug_rd_en,
  input  logic [31:0] debug_rdata,
  output logic        busy,
  output logic        done,
  output logic [8:0]  error_count,
  output logic [7:0]  first_err_addr
);

  state_t     state_q;
  logic [7:0] base_q, addr_q, seed_q;
  logic [8:0] len_q, rem_q;
  logic       verify_q;
  logic [7:0] wr_lfsr_q, chk_lfsr_q;
  logic [7:0] wr_lfsr_d, chk_lfsr_d;
  logic       tvalid_q, rd_en_q, busy_q, done_q;
  logic [8:0] err_cnt_q;
  logic [7:0] first_err_q;
  logic [8:0] len_clamped;
  logic [7:0] seed_fixed;

  lfsr8_step #(.LFSR_TAPS(LFSR_TAPS)) u_wr_step (
    .state_i (wr_lfsr_q),
    .next_o  (wr_lfsr_d)
  );

  lfsr8_step #(.LFSR_TAPS(LFSR_TAPS)) u_chk_step (
    .state_i (chk_lfsr_q),
    .next_o  (chk_lfsr_d)
  );

  assign len_clamped = clamp_len(length);
  assign seed_fixed  = fix_seed(seed);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      seed_q      <= 8'h01;
      len_q       <= '0;
      rem_q       <= '0;
      verify_q    <= 1'b0;
      wr_lfsr_q   <= 8'h01;
      chk_lfsr_q  <= 8'h01;
      tvalid_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments only; the default below is
      // overridden later in the same block, giving a one-cycle done pulse.
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            addr_q      <= base_addr;
            len_q       <= len_clamped;
            rem_q       <= len_clamped;
            seed_q      <= seed_fixed;
            wr_lfsr_q   <= seed_fixed;
            verify_q    <= verify_en;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            busy_q      <= 1'b1;
            if (len_clamped == 9'd0) begin
              state_q <= ST_DONE;
            end else begin
              state_q  <= ST_WRITE;
              tvalid_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (m_axis_tready) begin
            wr_lfsr_q <= wr_lfsr_d;
            if (rem_q == 9'd1) begin
              // Rewind address and pattern so the read-back starts at beat 0.
              tvalid_q   <= 1'b0;
              addr_q     <= base_q;
              chk_lfsr_q <= seed_q;
              rem_q      <= len_q;
              if (verify_q) begin
                state_q <= ST_VREQ;
                rd_en_q <= 1'b1;
              end else begin
                state_q <= ST_DONE;
              end
            end else begin
              addr_q <= addr_q + 8'd1;
              rem_q  <= rem_q - 9'd1;
            end
          end
        end
        ST_VREQ: begin
          rd_en_q <= 1'b0;
          state_q <= ST_VCHK;
        end
        ST_VCHK: begin
          if (debug_rdata[7:0] != chk_lfsr_q) begin
            if (err_cnt_q != MAX_LEN) err_cnt_q <= err_cnt_q + 9'd1;
            if (err_cnt_q == 9'd0) first_err_q <= addr_q;
          end
          chk_lfsr_q <= chk_lfsr_d;
          addr_q     <= addr_q + 8'd1;
          rem_q      <= rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_VREQ;
            rd_en_q <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tdata   = tvalid_q ? pack_beat(addr_q, wr_lfsr_q) : 32'h0;
  assign debug_addr     = addr_q;
  assign debug_rd_en    = rd_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error_count    = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_lfsr_axis_writer.sv
// Self-checking bench: RAM model slave with selectable backpressure, beat
// scoreboard, table of commands plus hand-written reset sequence.
module tb_lfsr_axis_writer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
  logic [7:0]  seed = '0;
  logic        verify_en = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  debug_addr;
  logic        debug_rd_en;
  logic [31:0] debug_rdata = '0;
  logic        busy, done;
  logic [8:0]  error_count;
  logic [7:0]  first_err_addr;

  lfsr_axis_writer dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .verify_en(verify_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .debug_addr(debug_addr),
    .debug_rd_en(debug_rd_en), .debug_rdata(debug_rdata), .busy(busy),
    .done(done), .error_count(error_count), .first_err_addr(first_err_addr)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // RAM model: 0 = always ready, 1 = pause one cycle after each beat, 2 = random.
  int         tready_mode = 0;
  logic       fault_arm = 1'b0;
  logic [7:0] mem [256];

  always @(posedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      mem[m_axis_tdata[23:16]] <= m_axis_tdata[7:0];
      if (fault_arm && m_axis_tdata[23:16] == 8'h13) mem[8'h12] <= 8'h00;
    end
    if (debug_rd_en) debug_rdata <= {24'h0, mem[debug_addr]};
    case (tready_mode)
      0:       m_axis_tready <= 1'b1;
      1:       m_axis_tready <= !(m_axis_tvalid && m_axis_tready);
      default: m_axis_tready <= ($urandom_range(0, 1) == 1);
    endcase
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic [31:0] exp_q[$];
  int          beat_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_tdata = '0;

  always @(negedge aclk) begin
    if (prev_stall && aresetn) begin
      check("stall_tvalid", {31'h0, m_axis_tvalid}, 32'h1);
      check("stall_tdata", m_axis_tdata, prev_tdata);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_tdata = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready) begin
      beat_cnt++;
      if (exp_q.size() == 0) check("spurious_beat", 32'(exp_q.size()), 32'h1);
      else check("beat", m_axis_tdata, exp_q.pop_front());
    end
  end

  function automatic logic [7:0] model_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic push_expected(input logic [7:0] b, input logic [8:0] l, input logic [7:0] s);
    int         n;
    logic [7:0] st;
    n  = (l > 9'd256) ? 256 : int'(l);
    st = (s == 8'h00) ? 8'h01 : s;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({8'h00, 8'(b + 8'(k)), 8'h00, st});
      st = model_step(st);
    end
  endtask

  task automatic run_cmd(input logic [7:0] b, input logic [8:0] l, input logic [7:0] s,
                         input logic v, input int mode, input logic flt, input int mid,
                         input int exp_tvalid, output int cycles);
    bit got;
    @(negedge aclk);
    tready_mode = mode;
    fault_arm   = flt;
    beat_cnt    = 0;
    push_expected(b, l, s);
    base_addr = b; length = l; seed = s; verify_en = v; start = 1'b1;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 3000) begin
      @(posedge aclk);
      cycles++;
      @(negedge aclk);
      if (cycles == 1) begin
        start = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'h1);
        check("tvalid_after_start", {31'h0, m_axis_tvalid}, 32'(exp_tvalid));
      end
      if (mid != 0 && cycles == mid) begin
        base_addr = 8'h80; length = 9'd2; seed = 8'h77; verify_en = 1'b1; start = 1'b1;
      end
      if (mid != 0 && cycles == mid + 1) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", {31'h0, got}, 32'h1);
    check("busy_at_done", {31'h0, busy}, 32'h0);
    fault_arm = 1'b0;
  endtask

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    logic [7:0] seed;
    logic       ver;
    int         mode;
    logic       flt;
    int         mid;
    int         exp_beats;
    int         exp_err;
    logic [7:0] exp_first;
    int         exp_cycles;
    logic       chk_ram;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cycles;
    logic [7:0] ram_exp [4];

    vecs[0] = '{8'h10, 9'd4,   8'h01, 1'b0, 0, 1'b0, 0, 4,   0, 8'h00, 6,   1'b1};
    vecs[1] = '{8'h10, 9'd4,   8'h01, 1'b0, 1, 1'b0, 0, 4,   0, 8'h00, -1,  1'b1};
    vecs[2] = '{8'h10, 9'd4,   8'h01, 1'b0, 2, 1'b0, 0, 4,   0, 8'h00, -1,  1'b1};
    vecs[3] = '{8'hFE, 9'd300, 8'h00, 1'b0, 0, 1'b0, 0, 256, 0, 8'h00, 258, 1'b0};
    vecs[4] = '{8'h10, 9'd4,   8'h01, 1'b1, 1, 1'b1, 0, 4,   1, 8'h12, -1,  1'b0};
    vecs[5] = '{8'h10, 9'd4,   8'h01, 1'b1, 0, 1'b0, 0, 4,   0, 8'h00, 14,  1'b1};
    vecs[6] = '{8'h20, 9'd0,   8'h55, 1'b1, 0, 1'b0, 0, 0,   0, 8'h00, 2,   1'b0};
    vecs[7] = '{8'hFE, 9'd300, 8'h00, 1'b1, 2, 1'b0, 0, 256, 0, 8'h00, -1,  1'b0};
    vecs[8] = '{8'h40, 9'd7,   8'hA3, 1'b1, 1, 1'b0, 0, 7,   0, 8'h00, -1,  1'b0};
    vecs[9] = '{8'h30, 9'd6,   8'h11, 1'b0, 1, 1'b0, 3, 6,   0, 8'h00, -1,  1'b0};
    ram_exp[0] = 8'h01; ram_exp[1] = 8'hB8; ram_exp[2] = 8'h5C; ram_exp[3] = 8'h2E;

    for (int a = 0; a < 256; a++) mem[a] = 8'hFF;

    // Reset state.
    #12;
    check("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_rd_en", {31'h0, debug_rd_en}, 32'h0);
    check("rst_debug_addr", {24'h0, debug_addr}, 32'h0);
    check("rst_error_count", {23'h0, error_count}, 32'h0);
    check("rst_first_err", {24'h0, first_err_addr}, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].base, vecs[i].len, vecs[i].seed, vecs[i].ver, vecs[i].mode,
              vecs[i].flt, vecs[i].mid, (vecs[i].exp_beats != 0) ? 1 : 0, cycles);
      check($sformatf("v%0d_beats", i), 32'(beat_cnt), 32'(vecs[i].exp_beats));
      check($sformatf("v%0d_queue_left", i), 32'(exp_q.size()), 32'h0);
      check($sformatf("v%0d_error_count", i), {23'h0, error_count}, 32'(vecs[i].exp_err));
      check($sformatf("v%0d_first_err", i), {24'h0, first_err_addr}, {24'h0, vecs[i].exp_first});
      if (vecs[i].exp_cycles >= 0)
        check($sformatf("v%0d_cycles", i), 32'(cycles), 32'(vecs[i].exp_cycles));
      if (vecs[i].chk_ram)
        for (int k = 0; k < 4; k++)
          check($sformatf("v%0d_ram_%0d", i, k), {24'h0, mem[8'h10 + k]}, {24'h0, ram_exp[k]});
      exp_q.delete();
    end

    // Reset asserted while beat 2 of a write is on the bus.
    @(negedge aclk);
    tready_mode = 0;
    beat_cnt = 0;
    push_expected(8'h50, 9'd8, 8'h3C);
    base_addr = 8'h50; length = 9'd8; seed = 8'h3C; verify_en = 1'b1; start = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    start = 1'b0;
    for (int c = 0; c < 50 && beat_cnt < 3; c++) @(negedge aclk);
    check("rst_mid_reached_beat2", 32'(beat_cnt), 32'h3);
    #1 aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_done", {31'h0, done}, 32'h0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    exp_q.delete();
    beat_cnt = 0;
    repeat (5) @(negedge aclk);
    check("post_rst_idle_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("post_rst_idle_busy", {31'h0, busy}, 32'h0);
    check("post_rst_no_beats", 32'(beat_cnt), 32'h0);
    check("post_rst_rd_en", {31'h0, debug_rd_en}, 32'h0);

    run_cmd(8'h50, 9'd3, 8'h3C, 1'b1, 0, 1'b0, 0, 1, cycles);
    check("post_rst_beats", 32'(beat_cnt), 32'h3);
    check("post_rst_cycles", 32'(cycles), 32'd11);
    check("post_rst_error_count", {23'h0, error_count}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
